led_scroll_feeder: RTL and testbench
====================================

# led_scroll_feeder

Upstream feeder for the four-digit seven-segment driver. Holds a message of up to 16 hex nibbles and presents a four-digit window of it on hex3..hex0, which connect directly to the driver's digit inputs. The window advances one digit per scroll period, or per single-step pulse, wrapping around the message so text scrolls leftward across the display.

## Interface
Parameters:
- SCROLL_DIV, 25000000: clock cycles per automatic scroll step; must be ≥2.
- CNT_W, 25: width of the scroll period counter; must satisfy 2^CNT_W ≥ SCROLL_DIV.

Ports:
- clk  in  1  system clock; all logic rises on posedge clk.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  write strobe for the message memory.
- wr_addr  in  4  message memory write address.
- wr_data  in  4  nibble to write.
- msg_last  in  4  index of the last valid message nibble; message length L = msg_last+1 (1..16).
- run  in  1  level; 1 = automatic scrolling.
- step  in  1  single-cycle pulse; advances the window by one while not running.
- hex3, hex2, hex1, hex0  out  4 each  window digits, registered; hex3 is leftmost.
- pos  out  4  current window start pointer (ptr).
- wrap  out  1  one-cycle pulse when ptr advances from msg_last to 0.
- busy  out  1  1 while the FSM is in RUN.

## Operation
- Memory: 16×4 register array. Reset clears every entry to 0. A write at wr_addr occurs on the clock edge where wr_en=1. Writes are accepted in any state, and at any address including addresses > msg_last.
- FSM states:
  - IDLE: counter held at 0. step=1 advances ptr.
  - RUN: counter increments every cycle. When the counter equals SCROLL_DIV-1, ptr advances and the counter returns to 0.
- Transitions:
  - IDLE→RUN on run=1. The counter is 0 on entry.
  - RUN→IDLE on run=0. The counter is cleared and no advance occurs on that edge.
  - step is ignored in RUN.
- Advance rule: ptr_next = (ptr==msg_last) ? 0 : ptr+1. wrap=1 for exactly the cycle after that edge only when ptr was msg_last.
- Out-of-range pointer: if ptr > msg_last (msg_last was lowered), ptr is forced to 0 on the next edge. This takes priority over any advance, and wrap is not asserted.
- Window indices: idx_k = (ptr+k) mod L for k = 0..3. hex3 = mem[idx_0], hex2 = mem[idx_1], hex1 = mem[idx_2], hex0 = mem[idx_3].
  - The modulo is exact for all L, including L < 4.
  - L=1: all four digits show mem[0].
  - L=2: hex3..hex0 show mem[p], mem[p^1], mem[p], mem[p^1].
- Simultaneous write and advance: both take effect on the same edge. The output window is computed from the updated ptr and memory.
- Reset values: ptr=0, counter=0, state=IDLE, hex3..hex0=0, pos=0, wrap=0, busy=0, memory all 0.
- Reset mid-scroll: all state returns immediately (asynchronously) to the reset values. After reset release, the FSM re-enters RUN on the first edge where run=1.

## Timing
- hex3..hex0 are registered from the current ptr and memory every cycle. After any ptr or memory change at edge n, the outputs reflect it at edge n+1.
- Write at edge n → the affected digit updates at edge n+1.
- pos is the ptr register itself, so it has zero added latency.
- RUN timing: with run first sampled high at edge e, advances occur at edges e+SCROLL_DIV, e+2·SCROLL_DIV, and so on.
- step: an advance occurs at the edge where step=1 is sampled in IDLE. Back-to-back step pulses give one advance per cycle.
- wrap is asserted for the cycle following the wrapping edge and is coincident with pos=0.
- busy equals (state==RUN), registered.

## Test plan
- Reset / load / window: after reset, all outputs are 0. Write mem[i]=i for i = 0..15, msg_last=15, IDLE. Expect hex3..hex0 = 0,1,2,3 and pos=0.
- Auto scroll with SCROLL_DIV=4: raise run at edge e. Expect pos=1 and busy=1 after edge e+4, pos=2 after edge e+8, and hex3..hex0 = 2,3,4,5 one cycle after that. After 16 advances, pos=0 with a single-cycle wrap pulse.
- Short-message wrap: msg_last=2, mem = A,B,C, pos=0. Expect hex3..hex0 = A,B,C,A. After one step: B,C,A,B. After a step from pos=2: pos=0, wrap=1 for one cycle.
- Mode edges: with run=1, pulse step and check pos is unchanged. Drop run when the counter is 3. Expect no advance, busy=0, and a later step advancing exactly once.
- Boundary changes: pos=10, then set msg_last=5. Expect pos=0 next cycle and wrap=0. A write to mem[pos] on the same edge as an advance must both land, with the window correct one cycle later.
- Reset mid-run: assert reset with pos=7 during RUN. Expect all outputs 0 immediately and memory cleared. Keep run held high through release; scrolling restarts with the first advance SCROLL_DIV cycles later.

Source files
------------

// File: rtl/led_scroll_feeder_if.sv
// Purpose: host-side bundle for the scroll feeder (message load, mode control, window outputs).
// Latency: none, wires only.
// Backpressure: none; every signal is a plain level or strobe.
//
// Signals:
//   wr_en/wr_addr/wr_data : message memory write port
//   msg_last              : index of last valid nibble (length = msg_last+1)
//   run/step              : auto-scroll level, single-step pulse
//   hex3..hex0            : registered window digits, hex3 leftmost
//   pos/wrap/busy         : window start pointer, wrap pulse, running flag
interface led_scroll_feeder_if;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] msg_last;
   logic       run;
   logic       step;
   logic [3:0] hex3;
   logic [3:0] hex2;
   logic [3:0] hex1;
   logic [3:0] hex0;
   logic [3:0] pos;
   logic       wrap;
   logic       busy;

   modport master (
      output wr_en, wr_addr, wr_data, msg_last, run, step,
      input  hex3, hex2, hex1, hex0, pos, wrap, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, msg_last, run, step,
      output hex3, hex2, hex1, hex0, pos, wrap, busy
   );
endinterface

// File: rtl/led_scroll_feeder.sv
// Purpose: 16-nibble message store presenting a scrolling 4-digit window to the 7-seg driver.
// Latency: ptr/memory change at edge n shows on hex3..hex0 at edge n+1; pos has no added latency.
// Backpressure: none; writes, steps and run are taken every cycle.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : led_scroll_feeder_if.slave (write port, msg_last, run/step in;
//                hex3..hex0, pos, wrap, busy out)
module led_scroll_feeder #(
   parameter int SCROLL_DIV = 25000000,
   parameter int CNT_W      = 25
) (
   input  logic                 clk,
   input  logic                 reset,
   led_scroll_feeder_if.slave   bus
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [3:0]       ptr;
   logic [3:0]       ptr_nxt;
   logic             wrap_nxt;
   logic             adv;
   logic             wrap_q;
   logic             busy_q;
   logic [3:0]       mem [16];
   logic [3:0]       hex_q [4];
   logic [3:0]       idx [4];
   logic [4:0]       len;

   // Next-state, scroll counter and pointer update.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      ptr_nxt   = ptr;
      wrap_nxt  = 1'b0;
      adv       = 1'b0;

      case (state)
         IDLE: begin
            adv = bus.step;
            if (bus.run) state_nxt = RUN;
         end
         RUN: begin
            // Dropping run clears the counter and suppresses the pending advance.
            if (!bus.run)              state_nxt = IDLE;
            else if (cnt == CNT_LAST)  adv       = 1'b1;
            else                       cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      // A pointer left beyond a shortened message snaps home without a wrap pulse.
      if (ptr > bus.msg_last) begin
         ptr_nxt = '0;
      end else if (adv) begin
         if (ptr == bus.msg_last) begin
            ptr_nxt  = '0;
            wrap_nxt = 1'b1;
         end else begin
            ptr_nxt  = ptr + 4'd1;
         end
      end
   end

   // Window indices: exact modulo of the message length, so short messages repeat.
   always_comb begin
      len = {1'b0, bus.msg_last} + 5'd1;
      for (int k = 0; k < 4; k++) begin
         idx[k] = 4'(({1'b0, ptr} + 5'(k)) % len);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ptr    <= '0;
         wrap_q <= 1'b0;
         busy_q <= 1'b0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         for (int k = 0; k < 4; k++) hex_q[k] <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         ptr    <= ptr_nxt;
         wrap_q <= wrap_nxt;
         busy_q <= (state_nxt == RUN);
         if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
         // Window is sampled from the current ptr/memory, hence one edge behind them.
         for (int k = 0; k < 4; k++) hex_q[k] <= mem[idx[k]];
      end
   end

   assign bus.hex3 = hex_q[0];
   assign bus.hex2 = hex_q[1];
   assign bus.hex1 = hex_q[2];
   assign bus.hex0 = hex_q[3];
   assign bus.pos  = ptr;
   assign bus.wrap = wrap_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_scroll_feeder.sv
// Purpose: scoreboard bench for led_scroll_feeder with a short scroll period.
// Latency: expectations are tagged with the clock edge after which they hold.
// Backpressure: none; the monitor compares at each falling edge (or on demand).
module tb_led_scroll_feeder;

   localparam int DIV = 4;

   typedef struct {
      int unsigned at;
      logic [15:0] hex;
      logic [3:0]  pos;
      logic        wrap;
      logic        busy;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int unsigned edges = 0;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        q [$];
   string       nq [$];
   event        chk_now;

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   led_scroll_feeder_if bus();

   led_scroll_feeder #(.SCROLL_DIV(DIV), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue an expectation that must hold after d more clock edges.
   task automatic push_exp(input int unsigned d, input string nm, input logic [15:0] h,
                           input logic [3:0] p, input logic w, input logic b);
      exp_t e;
      e.at   = edges + d;
      e.hex  = h;
      e.pos  = p;
      e.wrap = w;
      e.busy = b;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   // Monitor: compares queued expectations whose edge tag has been reached.
   initial begin
      exp_t        e;
      string       nm;
      logic [15:0] act;
      forever begin
         @(negedge clk or chk_now);
         while (q.size() != 0 && q[0].at <= edges) begin
            e   = q.pop_front();
            nm  = nq.pop_front();
            act = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            vectors++;
            if (e.at < edges) begin
               miscompares++;
               $display("FAIL %s: check slot missed (edge %0d, now %0d)", nm, e.at, edges);
            end else if (act !== e.hex || bus.pos !== e.pos ||
                         bus.wrap !== e.wrap || bus.busy !== e.busy) begin
               miscompares++;
               $display("FAIL %s: got hex=%h pos=%0d wrap=%b busy=%b, need hex=%h pos=%0d wrap=%b busy=%b",
                        nm, act, bus.pos, bus.wrap, bus.busy, e.hex, e.pos, e.wrap, e.busy);
            end
         end
      end
   end

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_addr  = 4'd0;
      bus.wr_data  = 4'd0;
      bus.msg_last = 4'd15;
      bus.run      = 1'b0;
      bus.step     = 1'b0;

      // Reset state, then load mem[i]=i.
      tick(2);
      push_exp(0, "reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 4'(i);
         bus.wr_data = 4'(i);
         tick(1);
      end
      bus.wr_en = 1'b0;
      tick(1);
      push_exp(0, "load", 16'h0123, 4'd0, 1'b0, 1'b0);

      // Auto scroll: run sampled at edge e = now+1.
      bus.run = 1'b1;
      push_exp(1,  "run_entry",    16'h0123, 4'd0,  1'b0, 1'b1);
      push_exp(4,  "run_no_early", 16'h0123, 4'd0,  1'b0, 1'b1);
      push_exp(5,  "run_adv1",     16'h0123, 4'd1,  1'b0, 1'b1);
      push_exp(9,  "run_adv2",     16'h1234, 4'd2,  1'b0, 1'b1);
      push_exp(10, "run_win",      16'h2345, 4'd2,  1'b0, 1'b1);
      push_exp(61, "run_adv15",    16'hEF01, 4'd15, 1'b0, 1'b1);
      push_exp(65, "run_wrap",     16'hF012, 4'd0,  1'b1, 1'b1);
      push_exp(66, "run_wrap_end", 16'h0123, 4'd0,  1'b0, 1'b1);
      tick(66);

      // Mode edges: step ignored in RUN; drop run when counter is 3.
      bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
      push_exp(0, "run_step_ignored", 16'h0123, 4'd0, 1'b0, 1'b1);
      tick(1);
      bus.run = 1'b0;
      push_exp(1, "run_drop",  16'h0123, 4'd0, 1'b0, 1'b0);
      push_exp(2, "idle_hold", 16'h0123, 4'd0, 1'b0, 1'b0);
      tick(3);
      bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
      push_exp(0, "step_adv",  16'h0123, 4'd1, 1'b0, 1'b0);
      push_exp(1, "step_win",  16'h1234, 4'd1, 1'b0, 1'b0);
      push_exp(3, "step_once", 16'h1234, 4'd1, 1'b0, 1'b0);
      tick(3);

      // Short message A,B,C (ptr currently 1).
      bus.msg_last = 4'd2;
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 4'd0; bus.wr_data = 4'hA; tick(1);
      bus.wr_addr  = 4'd1; bus.wr_data = 4'hB; tick(1);
      bus.wr_addr  = 4'd2; bus.wr_data = 4'hC; tick(1);
      bus.wr_en    = 1'b0;
      bus.step     = 1'b1;
      tick(1);
      push_exp(0, "short_step1", 16'hBCAB, 4'd2, 1'b0, 1'b0);
      tick(1);
      push_exp(0, "short_wrap",  16'hCABC, 4'd0, 1'b1, 1'b0);
      bus.step = 1'b0;
      tick(1);
      push_exp(0, "short_win",   16'hABCA, 4'd0, 1'b0, 1'b0);
      bus.step = 1'b1;
      tick(1);
      push_exp(0, "short_adv",   16'hABCA, 4'd1, 1'b0, 1'b0);
      bus.step = 1'b0;
      tick(1);
      push_exp(0, "short_win2",  16'hBCAB, 4'd1, 1'b0, 1'b0);

      // Lengths 2 and 1.
      bus.msg_last = 4'd1;
      tick(1);
      push_exp(0, "len2_win", 16'hBABA, 4'd1, 1'b0, 1'b0);
      bus.msg_last = 4'd0;
      tick(1);
      push_exp(0, "len1_force", 16'hAAAA, 4'd0, 1'b0, 1'b0);
      bus.step = 1'b1;
      tick(1);
      push_exp(0, "len1_step_wrap", 16'hAAAA, 4'd0, 1'b1, 1'b0);

      // Boundary: pos=10, then shrink to msg_last=5.
      bus.msg_last = 4'd15;
      tick(10);
      push_exp(0, "pos10", 16'h9ABC, 4'd10, 1'b0, 1'b0);
      bus.step     = 1'b0;
      bus.msg_last = 4'd5;
      tick(1);
      push_exp(0, "oor_force", 16'h45AB, 4'd0, 1'b0, 1'b0);
      tick(1);
      push_exp(0, "oor_win",   16'hABC3, 4'd0, 1'b0, 1'b0);

      // Write mem[pos] on the same edge as an advance (length 4 so it stays visible).
      bus.msg_last = 4'd3;
      bus.step     = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 4'd0;
      bus.wr_data  = 4'hE;
      tick(1);
      push_exp(0, "wr_adv", 16'hABC3, 4'd1, 1'b0, 1'b0);
      bus.step  = 1'b0;
      bus.wr_en = 1'b0;
      tick(1);
      push_exp(0, "wr_adv_win", 16'hBC3E, 4'd1, 1'b0, 1'b0);

      // Reset mid-run at pos=7.
      bus.msg_last = 4'd15;
      bus.run      = 1'b1;
      tick(25);
      push_exp(0, "pos7_run", 16'h6789, 4'd7, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      push_exp(0, "reset_async", 16'h0000, 4'd0, 1'b0, 1'b0);
      ->chk_now;
      tick(1);
      push_exp(0, "reset_hold", 16'h0000, 4'd0, 1'b0, 1'b0);
      tick(1);
      reset = 1'b0;
      push_exp(1, "rst_run_entry", 16'h0000, 4'd0, 1'b0, 1'b1);
      push_exp(4, "rst_no_early",  16'h0000, 4'd0, 1'b0, 1'b1);
      push_exp(5, "rst_adv1",      16'h0000, 4'd1, 1'b0, 1'b1);
      push_exp(6, "mem_cleared",   16'h0000, 4'd1, 1'b0, 1'b1);
      tick(7);
      bus.run = 1'b0;

      for (int k = 0; k < 50 && q.size() != 0; k++) tick(1);
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expectations still pending, need 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
